hamming_counter_secded: RTL and testbench
=========================================

# hamming_counter_secded

Parametrised up/down counter whose state is held only as a SECDED (extended Hamming) codeword. Every cycle the stored word is decoded, single-bit errors are corrected and scrubbed back, and double-bit errors are flagged and frozen. It is the next generation of the team's 16-bit Hamming-protected counter, adding a width parameter, double-error detection, load, direction control, error statistics and a built-in fault-injection path, so benches no longer need `force`.

## Interface
- WIDTH, 16: counter data width, 4..64.
- ERR_CNT_W, 8: width of the saturating corrected-error counter.
- Derived, not overridable: P = smallest integer with 2^P >= WIDTH+P+1 (P=5 for 16); CW = WIDTH+P+1 (22 for 16).
- clk  in  1  clock, all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  count one step this cycle.
- up_dn  in  1  1 = increment, 0 = decrement.
- load  in  1  load load_val, overriding everything except rst.
- load_val  in  WIDTH  value to load.
- clr_err  in  1  clear ded_sticky and err_cnt.
- inj_en  in  1  apply inj_mask to the word being written this cycle.
- inj_mask  in  CW  bit flips XORed into the encoded write data.
- counter  out  WIDTH  corrected data decoded from the stored word (combinational).
- sec_err  out  1  the stored word has a correctable single error (combinational).
- ded_err  out  1  the stored word has an uncorrectable double error (combinational).
- ded_sticky  out  1  registered; set by ded_err, held until clr_err or load.
- err_cnt  out  ERR_CNT_W  registered, saturating count of cycles with sec_err=1.
- syndrome  out  P+1  {overall parity, Hamming syndrome} of the stored word.

## Operation
- Codeword layout: bit 0 is overall parity (XOR of bits 1..CW-1). Bits 1..CW-1 are the Hamming positions, with parity at positions 2^k. Data bits fill the remaining positions in ascending order, data LSB first.
- Decode: syndrome s = XOR of the indices of the set bits. The decode is classified as follows:
  - s=0 and overall parity ok: clean.
  - overall parity bad: single error. Flip bit s (bit 0 when s=0). Assert sec_err.
  - s≠0 and overall parity ok: double error. Assert ded_err. counter outputs uncorrected data bits.
- Next data, in priority order:
  - load: next = load_val.
  - ded_err or ded_sticky: hold; the stored word is not rewritten.
  - enable: next = corrected ± 1, modulo 2^WIDTH. Wraps 2^WIDTH-1→0 up and 0→2^WIDTH-1 down.
  - otherwise: next = corrected data (scrub).
- Write: the stored word becomes encode(next) XOR (inj_en ? inj_mask : 0) on every non-hold cycle. Injection is ignored on hold cycles.
- err_cnt increments by 1 when sec_err=1 and stops at its maximum value. clr_err has priority over the increment.
- ded_sticky is set on ded_err. It is cleared by clr_err or load; clear wins over a same-cycle set.
- A load always recovers from the DED freeze.

## Timing
- Reset values: stored word = encode(0) = all zeros, so counter=0, sec_err=0, ded_err=0, syndrome=0, ded_sticky=0, err_cnt=0. Reset takes effect immediately, including mid-count or mid-freeze.
- Latency: an enable in cycle n is visible on counter after edge n+1.
- An injected error written at edge n is flagged on sec_err/ded_err in cycle n+1. A single error is scrubbed at edge n+2 (counter never shows it). err_cnt is updated at edge n+2.
- Simultaneous load + enable: load wins. Simultaneous enable + single error: the count advances from the corrected value and the word is written clean.

## Structure
- Package hamming_secded_pkg holds:
  - function calc_p(width);
  - functions secded_encode and secded_decode, parametrised on WIDTH through a parameterised class or a width-generic implementation;
  - a localparam for the overall-parity bit index.
- Sub-module secded_dec (WIDTH in; codeword in; data, sec, ded, syndrome out) is purely combinational and reusable for other protected registers.
- The top level holds the codeword register, next-state mux, err_cnt and ded_sticky.

## Test plan
- Reset, then enable=1 up_dn=1 for 45 cycles -> counter=16'h002D, all flags 0, err_cnt=0.
- At count 0x002D, inj_en with inj_mask=22'h000020 (one data bit) -> next cycle sec_err=1 and counter=0x002D. The following cycle sec_err=0, err_cnt=1. Counting continues 0x002E….
- inj_mask=22'h000028 (two bits) -> ded_err=1, ded_sticky=1, counter frozen despite enable for 5 cycles. Then load=1 load_val=16'h1234 -> counter=0x1234, ded_sticky=0.
- load 16'h0000, up_dn=0, enable one cycle -> counter=16'hFFFF. Then up_dn=1, one enable -> 16'h0000.
- Inject a single error on 300 consecutive writes with ERR_CNT_W=8 -> err_cnt saturates at 255. clr_err -> 0.
- Assert rst asynchronously mid-count at 0x0010 between edges -> counter=0 and all outputs at reset values immediately. Resume counting from 0 after release.

Source files
------------

// File: rtl/hamming_secded_pkg.sv
// SECDED (extended Hamming) helpers shared by protected registers.
// Functions work on max-width vectors and take the data width as an argument.
package hamming_secded_pkg;

    localparam int MAX_W           = 64;
    localparam int MAX_P           = 7;
    localparam int MAX_CW          = MAX_W + MAX_P + 1;
    localparam int OVERALL_PAR_BIT = 0;

    typedef struct packed {
        logic [MAX_W-1:0] data;
        logic [MAX_P-1:0] syn;
        logic             par;
        logic             sec;
        logic             ded;
    } secded_dec_t;

    function automatic int calc_p(input int width);
        int p;
        p = 1;
        while ((1 << p) < (width + p + 1)) begin
            p = p + 1;
        end
        return p;
    endfunction

    function automatic logic is_pow2(input int pos);
        return ((pos & (pos - 1)) == 0);
    endfunction

    function automatic logic [MAX_CW-1:0] secded_encode(input int width, input logic [MAX_W-1:0] data);
        logic [MAX_CW-1:0] word;
        logic [MAX_P-1:0]  s;
        int                j;
        int                cw;
        word = {MAX_CW{1'b0}};
        s    = {MAX_P{1'b0}};
        j    = 0;
        cw   = width + calc_p(width) + 1;
        for (int pos = 1; pos < MAX_CW; pos++) begin
            if ((pos < cw) && !is_pow2(pos)) begin
                word[pos] = data[j];
                if (data[j]) begin
                    s = s ^ MAX_P'(pos);
                end
                j = j + 1;
            end
        end
        // Parity bits cancel the data syndrome so a clean word decodes to zero.
        for (int k = 0; k < MAX_P; k++) begin
            if ((1 << k) < cw) begin
                word[1 << k] = s[k];
            end
        end
        word[OVERALL_PAR_BIT] = ^word;
        return word;
    endfunction

    function automatic secded_dec_t secded_decode(input int width, input logic [MAX_CW-1:0] word);
        secded_dec_t       r;
        logic [MAX_CW-1:0] corr;
        int                j;
        int                cw;
        r    = '{default: 1'b0};
        cw   = width + calc_p(width) + 1;
        for (int pos = 1; pos < MAX_CW; pos++) begin
            if ((pos < cw) && word[pos]) begin
                r.syn = r.syn ^ MAX_P'(pos);
            end
        end
        r.par = ^word;
        r.sec = r.par;
        r.ded = !r.par && (r.syn != {MAX_P{1'b0}});
        corr  = word;
        if (r.par && (int'(r.syn) < cw)) begin
            corr[r.syn] = ~corr[r.syn];
        end
        j = 0;
        for (int pos = 1; pos < MAX_CW; pos++) begin
            if ((pos < cw) && !is_pow2(pos)) begin
                r.data[j] = corr[pos];
                j = j + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/secded_dec.sv
// Combinational SECDED decoder: corrects single errors, flags double errors.
module secded_dec
    import hamming_secded_pkg::*;
#(
    parameter int  WIDTH = 16,
    localparam int P     = calc_p(WIDTH),
    localparam int CW    = WIDTH + P + 1
) (
    input  logic [CW-1:0]    codeword,
    output logic [WIDTH-1:0] data,
    output logic             sec,
    output logic             ded,
    output logic [P:0]       syndrome
);

    secded_dec_t dec_s;
    logic        unused_dec_s;

    // Decode the zero-extended codeword.
    always_comb begin
        dec_s = secded_decode(WIDTH, MAX_CW'(codeword));
    end

    assign data         = dec_s.data[WIDTH-1:0];
    assign sec          = dec_s.sec;
    assign ded          = dec_s.ded;
    assign syndrome     = {dec_s.par, dec_s.syn[P-1:0]};
    assign unused_dec_s = ^dec_s;

endmodule

// File: rtl/hamming_counter_secded.sv
// Up/down counter whose only state is a SECDED codeword, scrubbed every cycle,
// frozen on double errors, with error statistics and write-path fault injection.
module hamming_counter_secded
    import hamming_secded_pkg::*;
#(
    parameter int  WIDTH     = 16,
    parameter int  ERR_CNT_W = 8,
    localparam int P         = calc_p(WIDTH),
    localparam int CW        = WIDTH + P + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 up_dn,
    input  logic                 load,
    input  logic [WIDTH-1:0]     load_val,
    input  logic                 clr_err,
    input  logic                 inj_en,
    input  logic [CW-1:0]        inj_mask,
    output logic [WIDTH-1:0]     counter,
    output logic                 sec_err,
    output logic                 ded_err,
    output logic                 ded_sticky,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [P:0]           syndrome
);

    logic [CW-1:0]        code_q, code_d;
    logic                 ded_sticky_q, ded_sticky_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [WIDTH-1:0]     data_s;
    logic [WIDTH-1:0]     next_s;
    logic                 write_s;
    logic [MAX_CW-1:0]    enc_s;
    logic                 unused_enc_s;

    secded_dec #(.WIDTH(WIDTH)) u_dec (
        .codeword (code_q),
        .data     (data_s),
        .sec      (sec_err),
        .ded      (ded_err),
        .syndrome (syndrome)
    );

    // Next data selection and codeword write-back (load > freeze > count > scrub).
    always_comb begin
        next_s  = data_s;
        write_s = 1'b1;
        if (load) begin
            next_s = load_val;
        end else if (ded_err || ded_sticky_q) begin
            write_s = 1'b0;
        end else if (enable) begin
            next_s = up_dn ? (data_s + WIDTH'(1)) : (data_s - WIDTH'(1));
        end else begin
            next_s = data_s;
        end
        enc_s = secded_encode(WIDTH, MAX_W'(next_s));
        if (write_s) begin
            code_d = enc_s[CW-1:0] ^ (inj_en ? inj_mask : {CW{1'b0}});
        end else begin
            code_d = code_q;
        end
    end

    assign unused_enc_s = ^enc_s;

    // Error statistics: saturating single-error count and sticky double-error flag.
    always_comb begin
        err_cnt_d    = err_cnt_q;
        ded_sticky_d = ded_sticky_q;
        if (clr_err) begin
            err_cnt_d = {ERR_CNT_W{1'b0}};
        end else if (sec_err && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end else begin
            err_cnt_d = err_cnt_q;
        end
        if (clr_err || load) begin
            ded_sticky_d = 1'b0;
        end else if (ded_err) begin
            ded_sticky_d = 1'b1;
        end else begin
            ded_sticky_d = ded_sticky_q;
        end
    end

    // State registers; encode(0) is all zeros so reset is a plain clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code_q       <= {CW{1'b0}};
            ded_sticky_q <= 1'b0;
            err_cnt_q    <= {ERR_CNT_W{1'b0}};
        end else begin
            code_q       <= code_d;
            ded_sticky_q <= ded_sticky_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign counter    = data_s;
    assign ded_sticky = ded_sticky_q;
    assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_hamming_counter_secded.sv
// Bench for hamming_counter_secded: the model tracks the counter value plus the
// set of flipped codeword bits and derives the decode result from the error count.
module tb_hamming_counter_secded;

    localparam int W  = 16;
    localparam int EW = 8;
    localparam int P  = 5;
    localparam int CW = 22;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable, up_dn, load, clr_err, inj_en;
    logic [W-1:0]  load_val;
    logic [CW-1:0] inj_mask;
    logic [W-1:0]  counter;
    logic          sec_err, ded_err, ded_sticky;
    logic [EW-1:0] err_cnt;
    logic [P:0]    syndrome;

    int checks = 0;
    int errors = 0;

    logic [W-1:0]  m_val;
    logic [CW-1:0] m_flips;
    logic          m_sticky;
    int            m_cnt;

    hamming_counter_secded #(.WIDTH(W), .ERR_CNT_W(EW)) dut (
        .clk(clk), .rst(rst), .enable(enable), .up_dn(up_dn), .load(load),
        .load_val(load_val), .clr_err(clr_err), .inj_en(inj_en), .inj_mask(inj_mask),
        .counter(counter), .sec_err(sec_err), .ded_err(ded_err), .ded_sticky(ded_sticky),
        .err_cnt(err_cnt), .syndrome(syndrome)
    );

    always #5 clk = ~clk;

    function automatic int popc(input logic [CW-1:0] x);
        int n = 0;
        for (int i = 0; i < CW; i++) n += int'(x[i]);
        return n;
    endfunction

    // i-th data bit lives at the i-th codeword position >= 1 that is not a power of two
    function automatic int data_pos(input int i);
        int k = 0;
        for (int pos = 1; pos < CW; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                if (k == i) return pos;
                k++;
            end
        end
        return 0;
    endfunction

    function automatic logic [W-1:0] exp_counter();
        logic [W-1:0] v = m_val;
        if (popc(m_flips) == 2) begin
            for (int i = 0; i < W; i++) if (m_flips[data_pos(i)]) v[i] = ~v[i];
        end
        return v;
    endfunction

    function automatic logic [P:0] exp_syndrome();
        int s = 0;
        for (int pos = 1; pos < CW; pos++) if (m_flips[pos]) s = s ^ pos;
        return {popc(m_flips) % 2 == 1, s[P-1:0]};
    endfunction

    function automatic logic [CW-1:0] rand_mask(input int n);
        logic [CW-1:0] m = '0;
        while (popc(m) < n) m[$urandom_range(CW-1, 0)] = 1'b1;
        return m;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".counter"}, 32'(counter), 32'(exp_counter()));
        chk({tag, ".sec_err"}, 32'(sec_err), 32'(popc(m_flips) == 1));
        chk({tag, ".ded_err"}, 32'(ded_err), 32'(popc(m_flips) == 2));
        chk({tag, ".ded_sticky"}, 32'(ded_sticky), 32'(m_sticky));
        chk({tag, ".err_cnt"}, 32'(err_cnt), 32'(m_cnt));
        chk({tag, ".syndrome"}, 32'(syndrome), 32'(exp_syndrome()));
    endtask

    task automatic model_reset();
        m_val = '0; m_flips = '0; m_sticky = 1'b0; m_cnt = 0;
    endtask

    task automatic model_edge();
        logic sec, ded;
        sec = (popc(m_flips) == 1);
        ded = (popc(m_flips) == 2);
        if (clr_err) m_cnt = 0;
        else if (sec && m_cnt < (1 << EW) - 1) m_cnt++;
        if (load) begin
            m_val   = load_val;
            m_flips = inj_en ? inj_mask : '0;
        end else if (!(ded || m_sticky)) begin
            if (enable) m_val = up_dn ? m_val + 16'd1 : m_val - 16'd1;
            m_flips = inj_en ? inj_mask : '0;
        end
        if (clr_err || load) m_sticky = 1'b0;
        else if (ded) m_sticky = 1'b1;
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic idle();
        enable = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = '0;
        clr_err = 1'b0; inj_en = 1'b0; inj_mask = '0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b0;

        enable = 1'b1; up_dn = 1'b1;
        repeat (45) tick("count_up");
        chk("count45", 32'(counter), 32'h002D);

        enable = 1'b0; inj_en = 1'b1; inj_mask = 22'h000020;
        tick("inj_single");
        chk("inj_single_sec", 32'(sec_err), 32'd1);
        chk("inj_single_val", 32'(counter), 32'h002D);
        inj_en = 1'b0;
        tick("scrub");
        chk("scrub_sec", 32'(sec_err), 32'd0);
        chk("scrub_cnt", 32'(err_cnt), 32'd1);
        enable = 1'b1;
        tick("resume");
        chk("resume_val", 32'(counter), 32'h002E);

        enable = 1'b0; inj_en = 1'b1; inj_mask = 22'h000028;
        tick("inj_double");
        chk("inj_double_ded", 32'(ded_err), 32'd1);
        inj_en = 1'b0; enable = 1'b1;
        repeat (5) tick("frozen");
        chk("frozen_sticky", 32'(ded_sticky), 32'd1);
        load = 1'b1; load_val = 16'h1234;
        tick("load_recover");
        chk("load_val", 32'(counter), 32'h1234);
        chk("load_sticky", 32'(ded_sticky), 32'd0);

        load_val = 16'h0000; enable = 1'b0;
        tick("load_zero");
        load = 1'b0; up_dn = 1'b0; enable = 1'b1;
        tick("wrap_down");
        chk("wrap_down_val", 32'(counter), 32'hFFFF);
        up_dn = 1'b1;
        tick("wrap_up");
        chk("wrap_up_val", 32'(counter), 32'h0000);

        inj_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            enable   = 1'($urandom_range(1, 0));
            up_dn    = 1'($urandom_range(1, 0));
            inj_mask = rand_mask(1);
            tick("saturate");
        end
        inj_en = 1'b0; enable = 1'b0;
        tick("saturate_end");
        chk("saturated", 32'(err_cnt), 32'd255);
        clr_err = 1'b1;
        tick("clr_err");
        chk("cleared", 32'(err_cnt), 32'd0);
        clr_err = 1'b0;

        load = 1'b1; load_val = 16'h0000;
        tick("reload");
        load = 1'b0; enable = 1'b1; up_dn = 1'b1;
        repeat (16) tick("count_to_10");
        chk("count10", 32'(counter), 32'h0010);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        chk("async_rst_val", 32'(counter), 32'h0000);
        @(posedge clk);
        #1;
        check_all("rst_held");
        rst = 1'b0;
        tick("post_rst");
        chk("post_rst_val", 32'(counter), 32'h0001);

        for (int i = 0; i < 400; i++) begin
            enable   = 1'($urandom_range(3, 0) != 0);
            up_dn    = 1'($urandom_range(1, 0));
            load     = 1'($urandom_range(7, 0) == 0);
            load_val = 16'($urandom);
            clr_err  = 1'($urandom_range(15, 0) == 0);
            inj_en   = 1'($urandom_range(3, 0) == 0);
            inj_mask = rand_mask($urandom_range(2, 0));
            tick("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
